apb_slave_if: RTL and testbench
===============================

Name: apb_slave_if

Overview:
APB slave-side endpoint that sits directly downstream of the APB master interface on the shared APB bus. It decodes and checks each APB transfer, then forwards it as a single-request handshake to a local register or memory backend. It returns pready, prdata and pslverr to the bus, and generates error responses for decode faults and backend timeouts.

Parameters:
APB_DATA_WIDTH, 32, data bus width; multiple of 8.
APB_ADDR_WIDTH, 32, address bus width.
BASE_ADDR, 0, lowest byte address claimed by this slave.
ADDR_SPAN, 'h1000, number of bytes claimed; valid range is BASE_ADDR <= addr < BASE_ADDR+ADDR_SPAN.
TIMEOUT_CYCLE, 6, maximum backend wait cycles before an error response; >= 1.

Ports:
apb_clk_in  input  1  clock; all logic on posedge.
apb_rstn_in  input  1  asynchronous active-low reset.
apb_addr_in  input  APB_ADDR_WIDTH  paddr.
apb_psel_in  input  1  psel for this slave.
apb_penable_in  input  1  penable.
apb_write_in  input  1  pwrite.
apb_wdata_in  input  APB_DATA_WIDTH  pwdata.
apb_strb_in  input  APB_DATA_WIDTH/8  pstrb; present only under `APB_WSTRB`.
apb_prot_in  input  3  pprot; present only under `APB_PROT`.
apb_ready_out  output  1  pready.
apb_rdata_out  output  APB_DATA_WIDTH  prdata.
apb_slverr_out  output  1  pslverr.
other_sel_out  output  1  backend request, held until other_ready_in or timeout.
other_addr_out  output  APB_ADDR_WIDTH  backend offset (addr - BASE_ADDR).
other_write_out  output  1  backend direction.
other_wdata_out  output  APB_DATA_WIDTH  backend write data.
other_strb_out  output  APB_DATA_WIDTH/8  backend byte enables.
other_prot_out  output  3  backend pprot copy; present only under `APB_PROT`.
other_ready_in  input  1  backend done; sampled only while other_sel_out=1.
other_rdata_in  input  APB_DATA_WIDTH  backend read data; valid with other_ready_in.
other_error_in  input  1  backend error; valid with other_ready_in.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0. Wait counter 0.
- Registered outputs throughout, all updating on posedge.
- One-hot FSM with states IDLE, BUSY, RESP.
- IDLE, on apb_psel_in=1 and apb_penable_in=0 (setup phase), capture addr, write, wdata, strb and prot:
  - Decode error (addr outside range, or low log2(APB_DATA_WIDTH/8) addr bits nonzero): go to RESP with ready=1, slverr=1, rdata=0. No backend access.
  - Otherwise: go to BUSY with other_sel_out=1.
  - other_addr_out = addr - BASE_ADDR.
  - other_wdata_out = wdata on writes, 0 on reads.
  - other_strb_out = strb on writes; 0 on reads; all-ones on writes when `APB_WSTRB` is undefined.
- IDLE, apb_penable_in=1 without a preceding setup phase: ignored; stay IDLE.
- BUSY:
  - Wait counter increments each cycle that other_ready_in=0.
  - other_ready_in=1: go to RESP with other_sel_out=0, ready=1, slverr=other_error_in, rdata = write ? 0 : other_rdata_in.
  - Counter reaches TIMEOUT_CYCLE with no ready: go to RESP with other_sel_out=0, ready=1, slverr=1, rdata=0.
  - other_ready_in takes priority over timeout in the same cycle.
  - Counter width is $clog2(TIMEOUT_CYCLE+1); it clears on leaving BUSY.
- RESP: ready is held for exactly one cycle, then IDLE with ready, slverr and rdata cleared to 0.
- Latency:
  - Backend ready in the first BUSY cycle gives a 3-cycle transfer: setup, one wait, completion.
  - Decode error gives a 2-cycle transfer.
- Abort: apb_psel_in=0 while in BUSY or RESP returns to IDLE next edge with every output 0. The backend request is dropped.
- Back-to-back: a new setup phase in the cycle after completion is accepted normally from IDLE.
- apb_ready_out is never 1 while apb_penable_in=0.

Test Plan:
- BASE_ADDR='h4000. Write addr='h4010, wdata='hDEADBEEF, backend ready on first BUSY cycle -> other_addr_out='h10, other_wdata_out='hDEADBEEF, other_strb_out='hF, pready=1 in cycle 3, pslverr=0.
- Read addr='h4020, backend ready after 2 cycles with rdata='h12345678 -> prdata='h12345678 with pready. prdata returns to 0 the following cycle.
- Read addr='h5000 (out of range) and write addr='h4002 (unaligned) -> other_sel_out stays 0, pready=1 in cycle 2, pslverr=1, prdata=0.
- Backend never ready, TIMEOUT_CYCLE=6 -> other_sel_out high for 6 cycles, then pready=1 with pslverr=1. Repeat with other_ready_in rising on exactly the timeout cycle -> pslverr=other_error_in.
- Backend returns other_error_in=1 on a write -> pslverr=1, prdata=0.
- Reset asserted mid-BUSY, and psel dropped mid-BUSY -> all outputs 0 immediately (reset) or at the next edge (abort). A following write transfer completes normally.

Source files
------------

// File: rtl/apb_slave_if.sv
// APB slave endpoint: decodes each APB transfer, forwards it to a local backend as a
// single held request, and returns pready/prdata/pslverr with decode and timeout errors.
module apb_slave_if #(
    parameter int unsigned                  APB_DATA_WIDTH = 32,
    parameter int unsigned                  APB_ADDR_WIDTH = 32,
    parameter logic [APB_ADDR_WIDTH-1:0]    BASE_ADDR      = '0,
    parameter logic [APB_ADDR_WIDTH:0]      ADDR_SPAN      = 'h1000,
    parameter int unsigned                  TIMEOUT_CYCLE  = 6
) (
    input  logic                            apb_clk_in,
    input  logic                            apb_rstn_in,
    input  logic [APB_ADDR_WIDTH-1:0]       apb_addr_in,
    input  logic                            apb_psel_in,
    input  logic                            apb_penable_in,
    input  logic                            apb_write_in,
    input  logic [APB_DATA_WIDTH-1:0]       apb_wdata_in,
`ifdef APB_WSTRB
    input  logic [APB_DATA_WIDTH/8-1:0]     apb_strb_in,
`endif
`ifdef APB_PROT
    input  logic [2:0]                      apb_prot_in,
    output logic [2:0]                      other_prot_out,
`endif
    output logic                            apb_ready_out,
    output logic [APB_DATA_WIDTH-1:0]       apb_rdata_out,
    output logic                            apb_slverr_out,
    output logic                            other_sel_out,
    output logic [APB_ADDR_WIDTH-1:0]       other_addr_out,
    output logic                            other_write_out,
    output logic [APB_DATA_WIDTH-1:0]       other_wdata_out,
    output logic [APB_DATA_WIDTH/8-1:0]     other_strb_out,
    input  logic                            other_ready_in,
    input  logic [APB_DATA_WIDTH-1:0]       other_rdata_in,
    input  logic                            other_error_in
);

    localparam int unsigned SW = APB_DATA_WIDTH / 8;
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLE + 1);
    localparam logic [APB_ADDR_WIDTH:0]   RANGE_LO   = {1'b0, BASE_ADDR};
    localparam logic [APB_ADDR_WIDTH:0]   RANGE_HI   = {1'b0, BASE_ADDR} + ADDR_SPAN;
    localparam logic [APB_ADDR_WIDTH-1:0] ALIGN_MASK = APB_ADDR_WIDTH'(SW - 1);
    localparam logic [CW-1:0]             CNT_LAST   = CW'(TIMEOUT_CYCLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_BUSY = 3'b010,
        ST_RESP = 3'b100
    } state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        ready_q, ready_d;
    logic                        slverr_q, slverr_d;
    logic [APB_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                        sel_q, sel_d;
    logic [APB_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                        write_q, write_d;
    logic [APB_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]               strb_q, strb_d;
`ifdef APB_PROT
    logic [2:0]                  prot_q, prot_d;
`endif

    logic                        setup;
    logic                        in_range;
    logic                        aligned;
    logic                        decode_err;
    logic [SW-1:0]               wr_strb;

    assign setup      = apb_psel_in & ~apb_penable_in;
    assign in_range   = ({1'b0, apb_addr_in} >= RANGE_LO) && ({1'b0, apb_addr_in} < RANGE_HI);
    assign aligned    = (apb_addr_in & ALIGN_MASK) == '0;
    assign decode_err = ~in_range | ~aligned;

`ifdef APB_WSTRB
    assign wr_strb = apb_strb_in;
`else
    assign wr_strb = '1;
`endif

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
            sel_q    <= 1'b0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
`ifdef APB_PROT
            prot_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            slverr_q <= slverr_d;
            rdata_q  <= rdata_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
`ifdef APB_PROT
            prot_q   <= prot_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        ready_d  = 1'b0;
        slverr_d = 1'b0;
        rdata_d  = '0;
        sel_d    = sel_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
`ifdef APB_PROT
        prot_d   = prot_q;
`endif

        case (state_q)
            ST_IDLE: begin
                sel_d = 1'b0;
                if (setup) begin
                    if (decode_err) begin
                        state_d  = ST_RESP;
                        ready_d  = 1'b1;
                        slverr_d = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        sel_d   = 1'b1;
                        addr_d  = apb_addr_in - BASE_ADDR;
                        write_d = apb_write_in;
                        wdata_d = apb_write_in ? apb_wdata_in : '0;
                        strb_d  = apb_write_in ? wr_strb : '0;
`ifdef APB_PROT
                        prot_d  = apb_prot_in;
`endif
                    end
                end
            end
            ST_BUSY: begin
                // Abort wins, then backend completion, then timeout.
                if (!apb_psel_in) begin
                    state_d = ST_IDLE;
                    sel_d   = 1'b0;
                end else if (other_ready_in) begin
                    state_d  = ST_RESP;
                    sel_d    = 1'b0;
                    ready_d  = 1'b1;
                    slverr_d = other_error_in;
                    rdata_d  = write_q ? '0 : other_rdata_in;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = ST_RESP;
                    sel_d    = 1'b0;
                    ready_d  = 1'b1;
                    slverr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                sel_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = 1'b0;
            end
        endcase

        // Backend fields only carry meaning while the request is held.
        if (!sel_d) begin
            addr_d  = '0;
            write_d = 1'b0;
            wdata_d = '0;
            strb_d  = '0;
`ifdef APB_PROT
            prot_d  = '0;
`endif
        end
    end

    assign apb_ready_out   = ready_q;
    assign apb_slverr_out  = slverr_q;
    assign apb_rdata_out   = rdata_q;
    assign other_sel_out   = sel_q;
    assign other_addr_out  = addr_q;
    assign other_write_out = write_q;
    assign other_wdata_out = wdata_q;
    assign other_strb_out  = strb_q;
`ifdef APB_PROT
    assign other_prot_out  = prot_q;
`endif

endmodule

// File: tb/tb_apb_slave_if.sv
// Randomized bench for apb_slave_if: a transaction-timeline model predicts every
// output cycle by cycle, and directed transfers pin the model with literal values.
module tb_apb_slave_if;

    localparam int unsigned         TO   = 6;
    localparam logic [31:0]         BASE = 32'h4000;
    localparam logic [32:0]         SPAN = 33'h1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        psel, pen, pwrite;
    logic [31:0] wdata;
`ifdef APB_WSTRB
    logic [3:0]  strb;
`endif
`ifdef APB_PROT
    logic [2:0]  prot;
    logic [2:0]  o_prot;
`endif
    logic        ready, slverr;
    logic [31:0] rdata;
    logic        o_sel, o_write;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_strb;
    logic        b_ready, b_err;
    logic [31:0] b_rdata;

    always #5 clk = ~clk;

    apb_slave_if #(
        .APB_DATA_WIDTH (32),
        .APB_ADDR_WIDTH (32),
        .BASE_ADDR      (BASE),
        .ADDR_SPAN      (SPAN),
        .TIMEOUT_CYCLE  (TO)
    ) dut (
        .apb_clk_in      (clk),
        .apb_rstn_in     (rst_n),
        .apb_addr_in     (addr),
        .apb_psel_in     (psel),
        .apb_penable_in  (pen),
        .apb_write_in    (pwrite),
        .apb_wdata_in    (wdata),
`ifdef APB_WSTRB
        .apb_strb_in     (strb),
`endif
`ifdef APB_PROT
        .apb_prot_in     (prot),
        .other_prot_out  (o_prot),
`endif
        .apb_ready_out   (ready),
        .apb_rdata_out   (rdata),
        .apb_slverr_out  (slverr),
        .other_sel_out   (o_sel),
        .other_addr_out  (o_addr),
        .other_write_out (o_write),
        .other_wdata_out (o_wdata),
        .other_strb_out  (o_strb),
        .other_ready_in  (b_ready),
        .other_rdata_in  (b_rdata),
        .other_error_in  (b_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Expected outputs for the current cycle.
    logic        e_ready, e_slverr, e_sel, e_write, e_zero;
    logic [31:0] e_rdata, e_addr, e_wdata;
    logic [3:0]  e_strb;

    // Observations of the current transfer, indexed by cycle within the transfer.
    int          xcyc = 0;
    int          obs_sel_cnt, obs_ready_at;
    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic [3:0]  obs_strb;
    logic        obs_slverr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic exp_none(input logic zero);
        e_ready = 0; e_slverr = 0; e_rdata = 0; e_sel = 0;
        e_addr = 0; e_write = 0; e_wdata = 0; e_strb = 0; e_zero = zero;
    endtask

    task automatic compare();
        chk("pready", ready, e_ready);
        chk("pslverr", slverr, e_slverr);
        chk("prdata", rdata, e_rdata);
        chk("other_sel", o_sel, e_sel);
        if (!pen) chk("pready_without_penable", ready, 1'b0);
        if (e_sel || e_zero) begin
            chk("other_addr", o_addr, e_addr);
            chk("other_write", o_write, e_write);
            chk("other_wdata", o_wdata, e_wdata);
            chk("other_strb", o_strb, e_strb);
        end
        if (xcyc == 1) begin
            obs_sel_cnt = 0; obs_ready_at = 0;
            obs_addr = 0; obs_wdata = 0; obs_strb = 0; obs_rdata = 0; obs_slverr = 0;
        end
        if (o_sel) begin
            obs_sel_cnt++;
            obs_addr = o_addr; obs_wdata = o_wdata; obs_strb = o_strb;
        end
        if (ready) begin
            obs_ready_at = xcyc; obs_rdata = rdata; obs_slverr = slverr;
        end
    endtask

    // Finish the current cycle (compare at negedge) and move to the next drive point.
    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle(input int n, input logic glitch);
        for (int i = 0; i < n; i++) begin
            psel = glitch; pen = glitch; addr = BASE; pwrite = $urandom_range(0, 1);
            b_ready = 0; b_rdata = $urandom; b_err = $urandom_range(0, 1);
            exp_none(0);
            tick();
        end
    endtask

    task automatic setup_phase(input logic [31:0] a, input logic w, input logic [31:0] wd);
        xcyc = 1;
        psel = 1; pen = 0; addr = a; pwrite = w; wdata = wd;
`ifdef APB_WSTRB
        strb = 4'($urandom);
`endif
`ifdef APB_PROT
        prot = 3'($urandom);
`endif
        b_ready = 0; b_rdata = $urandom; b_err = $urandom_range(0, 1);
        exp_none(0);
        tick();
    endtask

    task automatic exp_busy(input logic [31:0] a, input logic w, input logic [31:0] wd);
        exp_none(0);
        e_sel = 1; e_addr = a - BASE; e_write = w; e_wdata = w ? wd : 32'h0;
`ifdef APB_WSTRB
        e_strb = w ? strb : 4'h0;
`else
        e_strb = w ? 4'hF : 4'h0;
`endif
    endtask

    // lat = backend wait cycles before ready; lat >= TO means it never answers in time.
    task automatic do_xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                           input int lat, input logic berr, input logic [31:0] brd);
        longint unsigned la;
        logic dec;
        int   nb;
        la  = longint'(a);
        dec = (la < longint'(BASE)) || (la >= longint'(BASE) + longint'(SPAN)) || (la % 4 != 0);
        nb  = (lat < int'(TO)) ? lat + 1 : int'(TO);
        setup_phase(a, w, wd);
        if (!dec) begin
            for (int i = 0; i < nb; i++) begin
                xcyc++; pen = 1;
                b_ready = (i == lat);
                b_rdata = (i == lat) ? brd : $urandom;
                b_err   = (i == lat) ? berr : 1'($urandom);
                exp_busy(a, w, wd);
                tick();
            end
        end
        xcyc++; pen = 1; b_ready = 0; b_rdata = $urandom;
        exp_none(0);
        e_ready = 1;
        if (dec || lat >= int'(TO)) e_slverr = 1;
        else begin
            e_slverr = berr;
            e_rdata  = w ? 32'h0 : brd;
        end
        tick();
    endtask

    task automatic do_abort(input logic [31:0] a, input logic w, input logic [31:0] wd, input int k);
        setup_phase(a, w, wd);
        for (int i = 0; i < k; i++) begin
            xcyc++; pen = 1; b_ready = 0;
            exp_busy(a, w, wd);
            tick();
        end
        xcyc++; psel = 0; pen = 0;
        exp_busy(a, w, wd);
        tick();
        exp_none(1);
        tick();
    endtask

    task automatic pin(input string nm, input int sel_cnt, input int rdy_at, input logic err,
                       input logic [31:0] rd);
        chk({nm, "_sel_cycles"}, 64'(obs_sel_cnt), 64'(sel_cnt));
        chk({nm, "_ready_cycle"}, 64'(obs_ready_at), 64'(rdy_at));
        chk({nm, "_slverr"}, obs_slverr, err);
        chk({nm, "_rdata"}, obs_rdata, rd);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0: return BASE + 32'(SPAN) + ($urandom_range(0, 255) << 2);
            1: return BASE - 32'd4 - ($urandom_range(0, 255) << 2);
            2: return BASE + ($urandom_range(0, 1023) << 2) + $urandom_range(1, 3);
            3: return BASE + 32'(SPAN) - 32'd4;
            default: return BASE + ($urandom_range(0, 1023) << 2);
        endcase
    endfunction

    initial begin
        rst_n = 0; psel = 0; pen = 0; addr = 0; pwrite = 0; wdata = 0;
`ifdef APB_WSTRB
        strb = 0;
`endif
`ifdef APB_PROT
        prot = 0;
`endif
        b_ready = 0; b_rdata = 0; b_err = 0;
        exp_none(1);
        #3;
        compare();
        #9 rst_n = 1;
        @(posedge clk); #1;

        // Directed transfers with hand-derived expectations.
        do_xfer(32'h4010, 1, 32'hDEADBEEF, 0, 0, 32'h0);
        chk("wr_other_addr", obs_addr, 32'h10);
        chk("wr_other_wdata", obs_wdata, 32'hDEADBEEF);
        chk("wr_other_strb", obs_strb, 4'hF);
        pin("wr", 1, 3, 0, 32'h0);
        do_xfer(32'h4020, 0, 32'h0, 2, 0, 32'h12345678);
        pin("rd", 3, 5, 0, 32'h12345678);
        bus_idle(1, 0);
        do_xfer(32'h5000, 0, 32'h0, 0, 0, 32'h0);
        pin("oor", 0, 2, 1, 32'h0);
        do_xfer(32'h4002, 1, 32'h1, 0, 0, 32'h0);
        pin("unal", 0, 2, 1, 32'h0);
        do_xfer(32'h3FFC, 0, 32'h0, 0, 0, 32'h0);
        pin("below", 0, 2, 1, 32'h0);
        do_xfer(32'h4FFC, 0, 32'h0, 0, 0, 32'hA5A5A5A5);
        pin("top", 1, 3, 0, 32'hA5A5A5A5);
        do_xfer(32'h4040, 0, 32'h0, 10, 0, 32'h55AA55AA);
        pin("tmo", 6, 8, 1, 32'h0);
        do_xfer(32'h4044, 0, 32'h0, 5, 0, 32'h0BADF00D);
        pin("tmo_edge_ok", 6, 8, 0, 32'h0BADF00D);
        do_xfer(32'h4048, 0, 32'h0, 5, 1, 32'h0BADF00D);
        pin("tmo_edge_err", 6, 8, 1, 32'h0BADF00D);
        do_xfer(32'h404C, 1, 32'hCAFE0001, 1, 1, 32'hFFFFFFFF);
        pin("wr_err", 2, 4, 1, 32'h0);
        do_abort(32'h4050, 1, 32'h11112222, 2);
        chk("abort_sel_cycles", 64'(obs_sel_cnt), 64'd3);
        bus_idle(1, 1);
        do_xfer(32'h4054, 1, 32'h33334444, 0, 0, 32'h0);
        pin("after_abort", 1, 3, 0, 32'h0);

        // Randomized traffic.
        for (int t = 0; t < 200; t++) begin
            int op;
            op = $urandom_range(0, 19);
            if (op < 2) do_abort(BASE + ($urandom_range(0, 1023) << 2), 1'($urandom), $urandom,
                                 $urandom_range(1, TO - 1));
            else begin
                if (op == 2) bus_idle(1, 1);
                do_xfer(rand_addr(), 1'($urandom), $urandom, $urandom_range(0, TO + 1),
                        1'($urandom), $urandom);
            end
            bus_idle($urandom_range(0, 2), 0);
        end

        // Reset in the middle of a backend wait, then a normal write.
        setup_phase(32'h4060, 1, 32'h77778888);
        xcyc++; pen = 1; b_ready = 0;
        exp_busy(32'h4060, 1, 32'h77778888);
        tick();
        #2 rst_n = 0;
        #1;
        chk("rst_ready", ready, 1'b0);
        chk("rst_sel", o_sel, 1'b0);
        chk("rst_addr", o_addr, 32'h0);
        chk("rst_wdata", o_wdata, 32'h0);
        exp_none(1);
        tick();
        psel = 0; pen = 0;
        tick();
        rst_n = 1;
        tick();
        do_xfer(32'h4064, 1, 32'h9999AAAA, 1, 0, 32'h0);
        pin("after_rst", 2, 4, 0, 32'h0);
        bus_idle(2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
